// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, RV32I opcode/funct7 constants, issue entry.
// Pure declarations; no timing or flow-control content.
package alu_pkg;

  localparam logic [5:0] ALU_ZERO     = 6'd0;
  localparam logic [5:0] ALU_ADD      = 6'd1;
  localparam logic [5:0] ALU_SUB      = 6'd2;
  localparam logic [5:0] ALU_AND      = 6'd3;
  localparam logic [5:0] ALU_OR       = 6'd4;
  localparam logic [5:0] ALU_XOR      = 6'd5;
  localparam logic [5:0] ALU_SLL      = 6'd6;
  localparam logic [5:0] ALU_SRL      = 6'd7;
  localparam logic [5:0] ALU_SRA      = 6'd8;
  localparam logic [5:0] ALU_SLT      = 6'd9;
  localparam logic [5:0] ALU_SLTU     = 6'd10;
  localparam logic [5:0] ALU_EQ       = 6'd11;
  localparam logic [5:0] ALU_NE       = 6'd12;
  localparam logic [5:0] ALU_SGE      = 6'd13;
  localparam logic [5:0] ALU_SGEU     = 6'd14;
  localparam logic [5:0] ALU_PASS_IN2 = 6'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        is_branch;
    logic        illegal;
  } issue_entry_t;

  // funct3 map shared by OP and OP-IMM; alt selects SUB/SRA.
  function automatic logic [5:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [5:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-register handshake bundle: upstream instruction side and downstream ALU side.
// master = environment (upstream source + ALU sink), slave = the issue register.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [4:0]  rd;
  logic        is_branch;
  logic        illegal;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_op, alu_in1, alu_in2, rd, is_branch, illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_op, alu_in1, alu_in2, rd, is_branch, illegal
  );
endinterface

// File: rtl/alu_decode.sv
// RV32I -> ALU op/operand decode; purely combinational (zero latency).
// No flow control; illegal encodings collapse to a zeroed entry flagged illegal.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  input  logic [31:0]  rs1_data,
  input  logic [31:0]  rs2_data,
  output issue_entry_t ent
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [4:0]   rd_f;
  logic [31:0]  imm_i;
  logic [31:0]  imm_s;
  logic [31:0]  imm_u;
  logic [31:0]  shamt;
  logic         is_shift;
  issue_entry_t d;
  logic         ill;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd_f     = instr[11:7];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u    = {instr[31:12], 12'b0};
  assign shamt    = {27'b0, instr[24:20]};
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    d   = '0;
    ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        d.in1 = rs1_data;
        d.in2 = rs2_data;
        d.rd  = rd_f;
        d.op  = arith_op(funct3, funct7 == F7_ALT);
        ill   = !((funct7 == F7_BASE) ||
                  ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        d.in1 = rs1_data;
        d.in2 = is_shift ? shamt : imm_i;
        d.rd  = rd_f;
        d.op  = arith_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        // Shift immediates reuse funct7 as an encoding qualifier.
        if (funct3 == 3'b001)      ill = (funct7 != F7_BASE);
        else if (funct3 == 3'b101) ill = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
      end
      OPC_LUI: begin
        d.op  = ALU_PASS_IN2;
        d.in2 = imm_u;
        d.rd  = rd_f;
      end
      OPC_AUIPC: begin
        d.op  = ALU_ADD;
        d.in1 = pc;
        d.in2 = imm_u;
        d.rd  = rd_f;
      end
      OPC_LOAD: begin
        d.op  = ALU_ADD;
        d.in1 = rs1_data;
        d.in2 = imm_i;
        d.rd  = rd_f;
      end
      OPC_STORE: begin
        d.op  = ALU_ADD;
        d.in1 = rs1_data;
        d.in2 = imm_s;
      end
      OPC_BRANCH: begin
        d.in1       = rs1_data;
        d.in2       = rs2_data;
        d.is_branch = 1'b1;
        case (funct3)
          3'b000:  d.op = ALU_EQ;
          3'b001:  d.op = ALU_NE;
          3'b100:  d.op = ALU_SLT;
          3'b101:  d.op = ALU_SGE;
          3'b110:  d.op = ALU_SLTU;
          3'b111:  d.op = ALU_SGEU;
          default: ill  = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase

    ent = d;
    if (ill) begin
      ent         = '0;
      ent.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Execute issue register: decode into a 2-entry skid queue; 1-cycle latency, no comb in->out path.
// Backpressure: in_ready is registered (low only when both slots are full); flush clears the queue.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  alu_issue_if.slave io
);

  if (XLEN != 32 || DEPTH != 2) begin : g_param_check
    $error("alu_issue supports only XLEN=32, DEPTH=2");
  end

  typedef enum logic [1:0] {EMPTY, ONE, TWO} q_state_t;

  q_state_t     state;
  issue_entry_t slot [DEPTH];
  logic         in_ready_q;
  logic         out_valid_q;
  issue_entry_t dec;
  logic         push;
  logic         pop;

  alu_decode u_decode (
    .instr    (io.instr),
    .pc       (io.pc),
    .rs1_data (io.rs1_data),
    .rs2_data (io.rs2_data),
    .ent      (dec)
  );

  assign push = io.in_valid & in_ready_q;
  assign pop  = out_valid_q & io.out_ready;

  // slot[0] is always the head; slot[1] only holds data in TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      slot[0]     <= '0;
      slot[1]     <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            slot[0]     <= dec;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            slot[1]    <= dec;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (!push && pop) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (push && pop) begin
            slot[0] <= dec;
          end
        end
        TWO: begin
          if (pop) begin
            slot[0]    <= slot[1];
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.alu_op    = slot[0].op;
  assign io.alu_in1   = slot[0].in1;
  assign io.alu_in2   = slot[0].in2;
  assign io.rd        = slot[0].rd;
  assign io.is_branch = slot[0].is_branch;
  assign io.illegal   = slot[0].illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, streaming, backpressure, flush, async reset.
module tb_alu_issue;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  alu_issue_if bus ();

  alu_issue u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        br;
    logic        ill;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int i);
    bus.instr    = vecs[i].instr;
    bus.pc       = vecs[i].pc;
    bus.rs1_data = vecs[i].rs1;
    bus.rs2_data = vecs[i].rs2;
    bus.in_valid = 1'b1;
  endtask

  task automatic check_head(input string tag, input int i);
    chk($sformatf("%s[%0d].vld", tag, i), {31'b0, bus.out_valid}, 32'd1);
    chk($sformatf("%s[%0d].op", tag, i), {26'b0, bus.alu_op}, {26'b0, vecs[i].op});
    chk($sformatf("%s[%0d].in1", tag, i), bus.alu_in1, vecs[i].in1);
    chk($sformatf("%s[%0d].in2", tag, i), bus.alu_in2, vecs[i].in2);
    chk($sformatf("%s[%0d].rd", tag, i), {27'b0, bus.rd}, {27'b0, vecs[i].rd});
    chk($sformatf("%s[%0d].br", tag, i), {31'b0, bus.is_branch}, {31'b0, vecs[i].br});
    chk($sformatf("%s[%0d].ill", tag, i), {31'b0, bus.illegal}, {31'b0, vecs[i].ill});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".vld"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, ".rdy"}, {31'b0, bus.in_ready}, 32'd1);
    chk({tag, ".op"}, {26'b0, bus.alu_op}, 32'd0);
    chk({tag, ".in1"}, bus.alu_in1, 32'd0);
    chk({tag, ".in2"}, bus.alu_in2, 32'd0);
    chk({tag, ".rd"}, {27'b0, bus.rd}, 32'd0);
    chk({tag, ".br"}, {31'b0, bus.is_branch}, 32'd0);
    chk({tag, ".ill"}, {31'b0, bus.illegal}, 32'd0);
  endtask

  initial begin
    //          instr         pc            rs1           rs2           op  in1           in2           rd br ill
    vecs[0] = '{32'h003100B3, 32'h0,        32'd5,        32'd7,        6'd1,  32'd5,        32'd7,        5'd1, 1'b0, 1'b0}; // add x1,x2,x3
    vecs[1] = '{32'h40335293, 32'h0,        32'h80000000, 32'h0000DEAD, 6'd8,  32'h80000000, 32'd3,        5'd5, 1'b0, 1'b0}; // srai x5,x6,3
    vecs[2] = '{32'h123450B7, 32'h0,        32'h11111111, 32'h22222222, 6'd15, 32'd0,        32'h12345000, 5'd1, 1'b0, 1'b0}; // lui x1,0x12345
    vecs[3] = '{32'h0020F063, 32'h0,        32'd3,        32'd9,        6'd14, 32'd3,        32'd9,        5'd0, 1'b1, 1'b0}; // bgeu x1,x2,0
    vecs[4] = '{32'hFFFFFFFF, 32'h0,        32'd77,       32'd88,       6'd0,  32'd0,        32'd0,        5'd0, 1'b0, 1'b1}; // bad opcode
    vecs[5] = '{32'h403100B3, 32'h0,        32'd10,       32'd4,        6'd2,  32'd10,       32'd4,        5'd1, 1'b0, 1'b0}; // sub x1,x2,x3
    vecs[6] = '{32'h403110B3, 32'h0,        32'd10,       32'd4,        6'd0,  32'd0,        32'd0,        5'd0, 1'b0, 1'b1}; // sll w/ alt funct7
    vecs[7] = '{32'h00312423, 32'h0,        32'h00000100, 32'd3,        6'd1,  32'h00000100, 32'd8,        5'd0, 1'b0, 1'b0}; // sw x3,8(x2)
    vecs[8] = '{32'hFFF00093, 32'h0,        32'd0,        32'd0,        6'd1,  32'd0,        32'hFFFFFFFF, 5'd1, 1'b0, 1'b0}; // addi x1,x0,-1
    vecs[9] = '{32'h00001217, 32'h10000000, 32'd0,        32'd0,        6'd1,  32'h10000000, 32'h00001000, 5'd4, 1'b0, 1'b0}; // auipc x4,1

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.instr     = '0;
    bus.pc        = '0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    flush         = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n      = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;

    // Streaming: push and pop every cycle, head is always the latest instruction.
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      apply(i);
      tick();
      check_head("stream", i);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream.drain.vld", {31'b0, bus.out_valid}, 32'd0);

    // Backpressure: A and B fill the queue, C waits upstream.
    bus.out_ready = 1'b0;
    apply(0);
    tick();
    chk("bp.rdy1", {31'b0, bus.in_ready}, 32'd1);
    apply(1);
    tick();
    chk("bp.rdy2", {31'b0, bus.in_ready}, 32'd0);
    apply(2);
    tick();
    check_head("bp.stallA", 0);
    chk("bp.rdy3", {31'b0, bus.in_ready}, 32'd0);
    tick();
    check_head("bp.stallA2", 0);
    bus.out_ready = 1'b1;
    tick();
    check_head("bp.B", 1);
    chk("bp.rdy4", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check_head("bp.C", 2);
    tick();
    chk("bp.drain.vld", {31'b0, bus.out_valid}, 32'd0);

    // Flush while full, with an instruction offered the same cycle.
    bus.out_ready = 1'b0;
    apply(0);
    tick();
    apply(1);
    tick();
    apply(3);
    flush = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush2.vld", {31'b0, bus.out_valid}, 32'd0);
    chk("flush2.rdy", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("flush2.after.vld", {31'b0, bus.out_valid}, 32'd0);

    // Flush from ONE: the accepted-looking input that cycle must be dropped.
    bus.out_ready = 1'b0;
    apply(5);
    tick();
    apply(7);
    flush = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush1.vld", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    apply(8);
    tick();
    bus.in_valid = 1'b0;
    check_head("flush1.fresh", 8);
    tick();
    chk("flush1.drain.vld", {31'b0, bus.out_valid}, 32'd0);

    // Asynchronous reset mid-cycle with both slots occupied.
    bus.out_ready = 1'b0;
    apply(0);
    tick();
    apply(1);
    tick();
    bus.in_valid = 1'b0;
    chk("arst.pre.rdy", {31'b0, bus.in_ready}, 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check_zero("arst");
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    apply(2);
    tick();
    bus.in_valid = 1'b0;
    check_head("arst.post", 2);
    tick();
    chk("arst.post.drain", {31'b0, bus.out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue register that sits directly upstream of the 32-bit ALU. It decodes an RV32I instruction plus its register-file operands into the ALU's 6-bit op code and two 32-bit operands. It buffers the result in a 2-entry skid queue with valid/ready handshakes on both sides. The combinational ALU consumes `alu_op`/`alu_in1`/`alu_in2` straight from the queue head.

## Interface
Parameters:
- `XLEN`, 32: operand width; only 32 is supported.
- `DEPTH`, 2: skid-queue depth; fixed at 2.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous queue clear.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  block can accept this cycle; registered.
- `instr`  in  32  raw RV32I instruction word.
- `pc`  in  32  instruction address.
- `rs1_data`  in  32  register-file read of rs1.
- `rs2_data`  in  32  register-file read of rs2.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream consumes head this cycle.
- `alu_op`  out  6  ALU op code of head entry.
- `alu_in1`  out  32  operand 1 of head entry.
- `alu_in2`  out  32  operand 2 of head entry.
- `rd`  out  5  destination register of head entry.
- `is_branch`  out  1  head entry is a conditional branch.
- `illegal`  out  1  head entry failed decode.

## Operation
- ALU op codes:
  - 0 ZERO, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
  - 6 SLL, 7 SRL, 8 SRA.
  - 9 SLT, 10 SLTU, 11 EQ, 12 NE, 13 SGE, 14 SGEU, 15 PASS_IN2.
- Decode by opcode, `instr[6:0]`:
  - OP (0110011): funct3 000 gives ADD, or SUB when funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7=0100000; 110 OR; 111 AND. in1=rs1_data, in2=rs2_data.
  - OP funct7 check: funct7 must be 0000000; 0100000 is legal only with funct3 000 or 101. Anything else is illegal.
  - OP-IMM (0010011): same funct3 map, never SUB. in2 = sign-extended I-immediate.
  - OP-IMM shifts: in2 = zero-extended shamt `instr[24:20]`. SRAI requires funct7=0100000, SLLI/SRLI require 0000000, otherwise illegal.
  - LUI (0110111): PASS_IN2, in1=0, in2={instr[31:12],12'b0}.
  - AUIPC (0010111): ADD, in1=pc, in2 = U-immediate.
  - LOAD (0000011) / STORE (0100011): ADD, in1=rs1_data, in2 = sign-extended I-immediate (load) or S-immediate (store). For STORE, rd=0.
  - BRANCH (1100011): funct3 000 EQ, 001 NE, 100 SLT, 101 SGE, 110 SLTU, 111 SGEU. 010/011 are illegal. is_branch=1, rd=0.
  - Any other opcode: illegal.
- Illegal entries: still enqueued with op=0, in1=in2=0, rd=0, illegal=1.
- Queue states: EMPTY, ONE, TWO. push = in_valid & in_ready; pop = out_valid & out_ready.
  - EMPTY: push → ONE.
  - ONE: push & !pop → TWO; !push & pop → EMPTY; push & pop → ONE, with the new entry becoming head.
  - TWO: pop → ONE, with the second entry promoted. No push is possible.
- Ordering is strictly FIFO.
- `flush` outranks push and pop. Next state is EMPTY, any same-cycle in_valid is discarded, and a same-cycle pop is still counted as consumed.

## Timing
- Latency: instruction accepted at edge N appears on the outputs with out_valid=1 after edge N. That is one cycle, with no combinational path from inputs to outputs.
- `in_ready` = (state != TWO), registered; it has no combinational dependency on `out_ready`.
- Sustained throughput is 1 per cycle while `out_ready` is high.
- Output payload holds stable while out_valid=1 and out_ready=0.
- Reset (asynchronous, immediate on `rst_n` low, including mid-operation with entries held):
  - state=EMPTY, out_valid=0, in_ready=1.
  - alu_op=0, alu_in1=0, alu_in2=0, rd=0, is_branch=0, illegal=0.
- Reset release is synchronised by the system reset controller; the first push is allowed on the first edge after release.

## Structure
- Shared package `alu_pkg`:
  - 6-bit op-code localparams, 0 through 15, used by both this block and the ALU.
  - RV32I opcode and funct7 constants.
  - Packed struct `issue_entry_t` of {op, in1, in2, rd, is_branch, illegal}.
- One sub-module, `alu_decode`: purely combinational, from {instr, pc, rs1_data, rs2_data} to `issue_entry_t`.
- The top level holds the 2-entry queue and state register.

## Test plan
- Reset, then `instr`=0x003100B3 (add x1,x2,x3), rs1_data=5, rs2_data=7 → next cycle out_valid=1, alu_op=1, in1=5, in2=7, rd=1.
- `instr`=0x40335293 (srai x5,x6,3), rs1_data=0x80000000 → alu_op=8, in2=3, rd=5. Then `instr`=0x123450B7 (lui x1,0x12345) → alu_op=15, in1=0, in2=0x12345000.
- BRANCH with funct3=111 → alu_op=14, is_branch=1, rd=0. Then `instr`=0xFFFFFFFF → alu_op=0, illegal=1, in1=in2=0.
- Backpressure:
  - Hold out_ready=0 and present three back-to-back instructions. The first two are accepted and in_ready is low after the second push. The third is held upstream.
  - Raise out_ready: outputs emerge in order A, B, C, one per cycle.
  - Payload stays stable while stalled.
- Full queue (TWO) with flush=1 and in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed and same-cycle inputs never appear.
- Drop rst_n asynchronously mid-cycle with TWO entries → out_valid=0 and all outputs zero before the next edge. After release the queue behaves as EMPTY.
